// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix geometry, key legend table and FSM/result encodings.
package keypad_pkg;

    localparam int unsigned KP_ROWS = 4;
    localparam int unsigned KP_COLS = 4;
    localparam int unsigned KP_KEYS = KP_ROWS * KP_COLS;

    // Entry (row*KP_COLS + col) holds the hex legend printed on that key (Pmod KYPD layout).
    localparam logic [KP_KEYS*4-1:0] KP_CODE_TABLE = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    typedef enum logic {
        IDLE,
        HELD
    } kp_state_e;

    typedef enum logic {
        RES_NONE,
        RES_ONE
    } kp_class_e;

    function automatic logic [3:0] kp_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
        return KP_CODE_TABLE[4*int'({row_idx, col_idx}) +: 4];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to all-ones (idle pulled-up lines).
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, debounces whole-matrix scans
// and reports one key_valid pulse per accepted single-key press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 100_000,
    parameter int unsigned DEBOUNCE_SCANS = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned   TW         = $clog2(SCAN_DIV);
    localparam int unsigned   SW         = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STAB_MAX   = SW'(DEBOUNCE_SCANS);

    logic [KP_ROWS-1:0] row_sync;

    logic [TW-1:0]      timer_q, timer_d;
    logic [3:0]         col_q, col_d;
    logic [1:0]         col_idx_q, col_idx_d;
    logic [KP_KEYS-1:0] pressed_q, pressed_d;
    logic               scan_end;

    logic [4:0]         n_set;
    logic [3:0]         hit_idx;
    kp_class_e          cur_class;
    logic [3:0]         cur_code;

    kp_class_e          prev_class_q, prev_class_d;
    logic [3:0]         prev_code_q, prev_code_d;
    logic [SW-1:0]      stab_q, stab_d;
    kp_state_e          state_q, state_d;
    logic [3:0]         key_code_q, key_code_d;
    logic               key_valid_q, key_valid_d;
    logic               key_held_q, key_held_d;

    sync_2ff #(.WIDTH(KP_ROWS)) u_row_sync (
        .clk_i (clock),
        .rst_i (reset),
        .d_i   (row),
        .q_o   (row_sync)
    );

    // Rows are sampled on the last cycle of each column so the lines have settled.
    always_comb begin
        timer_d   = timer_q;
        col_d     = col_q;
        col_idx_d = col_idx_q;
        pressed_d = pressed_q;
        scan_end  = 1'b0;
        if (timer_q == TIMER_LAST) begin
            timer_d   = '0;
            col_d     = {col_q[2:0], col_q[3]};
            col_idx_d = col_idx_q + 2'd1;
            pressed_d[{col_idx_q, 2'b00} +: KP_ROWS] = ~row_sync;
            scan_end  = (col_idx_q == 2'd3);
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    // Pressed bit index is 4*col+row; two or more keys collapse to NONE so ghosts never surface.
    always_comb begin
        n_set   = '0;
        hit_idx = '0;
        for (int unsigned i = 0; i < KP_KEYS; i++) begin
            if (pressed_d[i]) begin
                n_set   = n_set + 5'd1;
                hit_idx = 4'(i);
            end
        end
        cur_class = (n_set == 5'd1) ? RES_ONE : RES_NONE;
        cur_code  = (n_set == 5'd1) ? kp_code(hit_idx[1:0], hit_idx[3:2]) : 4'h0;
    end

    always_comb begin
        prev_class_d = prev_class_q;
        prev_code_d  = prev_code_q;
        stab_d       = stab_q;
        state_d      = state_q;
        key_code_d   = key_code_q;
        key_valid_d  = 1'b0;
        key_held_d   = key_held_q;
        if (scan_end) begin
            prev_class_d = cur_class;
            prev_code_d  = cur_code;
            if (cur_class == prev_class_q && cur_code == prev_code_q) begin
                stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + SW'(1);
            end else begin
                stab_d = SW'(1);
            end
            if (state_q == IDLE) begin
                if (cur_class == RES_ONE && stab_d == STAB_MAX) begin
                    state_d     = HELD;
                    key_code_d  = cur_code;
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                end
            end else begin
                if (cur_class == RES_NONE && stab_d == STAB_MAX) begin
                    state_d    = IDLE;
                    key_held_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timer_q      <= '0;
            col_q        <= 4'b1110;
            col_idx_q    <= '0;
            pressed_q    <= '0;
            prev_class_q <= RES_NONE;
            prev_code_q  <= '0;
            stab_q       <= '0;
            state_q      <= IDLE;
            key_code_q   <= '0;
            key_valid_q  <= 1'b0;
            key_held_q   <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            col_q        <= col_d;
            col_idx_q    <= col_idx_d;
            pressed_q    <= pressed_d;
            prev_class_q <= prev_class_d;
            prev_code_q  <= prev_code_d;
            stab_q       <= stab_d;
            state_q      <= state_d;
            key_code_q   <= key_code_d;
            key_valid_q  <= key_valid_d;
            key_held_q   <= key_held_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
